modred_decap_cu: RTL and testbench
==================================

# modred_decap_cu

Control unit for the decapsulation modular-reduction stage. Accepts one 13-bit coefficient per handshake and drives the subtract-and-compare reduction datapath through its load/subtract/hold controls until the value is below q. It then returns the reduced coefficient downstream with a valid/ready handshake. It counts coefficients per polynomial frame and flags the last one; it sits directly upstream of the reduction datapath.

## Interface
Parameters:
- W, 13, coefficient/modulus width
- P, 761, coefficients per frame
- MAX_SUB, 8, subtraction limit per coefficient (watchdog only)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream coefficient valid
- in_ready  out  1  block can accept a coefficient
- in_data  in  W  unreduced coefficient
- q  in  W  modulus; held stable for a whole frame
- N  out  W  registered coefficient presented to the datapath
- R2  out  1  datapath control: 0 = load N
- R3  out  1  datapath control when R2=1: 0 = subtract q, 1 = hold
- Nmod  in  W  datapath register value
- out_valid  out  1  reduced coefficient valid
- out_ready  in  1  downstream accepts
- out_data  out  W  reduced coefficient
- out_last  out  1  out_data is coefficient P-1 of the frame
- frame_done  out  1  single-cycle pulse after the last beat is accepted
- busy  out  1  state is not IDLE
- err  out  1  sticky watchdog flag

## Operation
- States:
  - IDLE: in_ready=1, R2=1, R3=1. On in_valid, capture in_data into N and move to LOAD.
  - LOAD: R2=0, so the datapath loads N. Next state is CMP.
  - CMP: R2=1, R3=1.
    - Nmod >= q and q != 0: go to SUB.
    - Otherwise: register out_data<=Nmod and go to OUT.
  - SUB: R2=1, R3=0, sub_cnt++. Next state is CMP.
  - OUT: out_valid=1, R2=1, R3=1, in_ready=0. On out_ready, go to IDLE.
- Comparison is unsigned W-bit. Equality subtracts, so Nmod==q gives 0.
- q==0: no subtraction; the coefficient passes through unchanged.
- Frame counter:
  - Counts from 0 to P-1 and advances on each out_valid&&out_ready.
  - out_last = out_valid && (cnt==P-1).
  - After the last beat: the counter wraps to 0 and frame_done pulses in the next cycle.
- out_data and out_last stay stable while out_valid=1 && out_ready=0.
- Nmod has no reset. The block never reads Nmod before its first LOAD.

## Timing
- Reset values: state=IDLE, N=0, out_data=0, out_valid=0, out_last=0, frame_done=0, busy=0, err=0, cnt=0, sub_cnt=0. R2=1, R3=1 and in_ready=1 follow from IDLE.
- Latency: input handshake in cycle t, then k subtractions; out_valid first high in cycle t+3+2k.
- Throughput: at most one coefficient per 4 cycles (k=0, out_ready held high).
- Reset mid-operation: the in-flight coefficient is discarded and the frame count restarts at 0.
- in_valid is ignored outside IDLE. Upstream must hold in_data until in_ready.

## Configuration
- MODRED_WDOG_EN defined:
  - In CMP, if sub_cnt==MAX_SUB and Nmod >= q, set err (sticky until reset).
  - Go to OUT with out_data=Nmod.
  - sub_cnt clears on LOAD.
- MODRED_WDOG_EN undefined:
  - err is tied to 0 and no subtraction limit applies.
  - Ports are identical in both builds.

## Structure
- Shared package modred_pkg holds:
  - state enum (IDLE, LOAD, CMP, SUB, OUT)
  - W_COEF=13, P_SNTRUP=761, Q_SNTRUP=4591
  - encodings for the R2/R3 control pairs (LOAD, SUB, HOLD)
- One sub-module, modred_coef_cnt: the frame counter, producing out_last and frame_done.

## Test plan
- q=4591, in_data=5000 → one SUB cycle, out_data=409, out_valid at t+5.
- in_data=100 → no SUB, out_data=100 at t+3, R2 low exactly one cycle.
- in_data=4591 → out_data=0; in_data=4590 → out_data=4590.
- out_ready low for 10 cycles in OUT → out_data and out_valid held, in_ready=0, in_valid pulses ignored.
- 761 back-to-back coefficients → out_last only on beat 761, frame_done one cycle after it, next frame's out_last on beat 1522.
- q=0, in_data=8191 → out_data=8191. With MODRED_WDOG_EN, q=1, in_data=8191, MAX_SUB=8 → err=1, out_data=8183.
- rst_n asserted in SUB → all outputs at reset values immediately; the next coefficient reduces correctly.

Source files
------------

// File: rtl/modred_pkg.sv
// rtl/modred_pkg.sv - shared types and constants for the decapsulation modular-reduction control unit
package modred_pkg;

  localparam int W_COEF   = 13;
  localparam int P_SNTRUP = 761;
  localparam int Q_SNTRUP = 4591;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CMP,
    ST_SUB,
    ST_OUT
  } state_t;

  // Datapath control pair; r3 is a don't-care while r2 selects load.
  typedef struct packed {
    logic r2;
    logic r3;
  } dp_ctrl_t;

  localparam dp_ctrl_t DP_LOAD = '{r2: 1'b0, r3: 1'b1};
  localparam dp_ctrl_t DP_SUB  = '{r2: 1'b1, r3: 1'b0};
  localparam dp_ctrl_t DP_HOLD = '{r2: 1'b1, r3: 1'b1};

endpackage

// File: rtl/modred_decap_cu_if.sv
// rtl/modred_decap_cu_if.sv - coefficient stream, datapath control and status bundle
interface modred_decap_cu_if #(parameter int W = modred_pkg::W_COEF);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] q;
  logic [W-1:0] N;
  logic         R2;
  logic         R3;
  logic [W-1:0] Nmod;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         frame_done;
  logic         busy;
  logic         err;

  modport slave (
    input  in_valid, in_data, q, Nmod, out_ready,
    output in_ready, N, R2, R3, out_valid, out_data, out_last, frame_done, busy, err
  );

  modport master (
    output in_valid, in_data, q, Nmod, out_ready,
    input  in_ready, N, R2, R3, out_valid, out_data, out_last, frame_done, busy, err
  );

endinterface

// File: rtl/modred_coef_cnt.sv
// rtl/modred_coef_cnt.sv - per-frame coefficient counter producing out_last and frame_done
module modred_coef_cnt #(
  parameter int P = 761
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beat_valid_i,
  input  logic beat_ready_i,
  output logic out_last_o,
  output logic frame_done_o
);

  localparam int CW = (P > 1) ? $clog2(P) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          at_last, fire;

  assign at_last = (cnt_q == CW'(P - 1));
  assign fire    = beat_valid_i && beat_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (fire) cnt_d = at_last ? '0 : cnt_q + CW'(1);
  end

  assign frame_done_d = fire && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_last_o   = beat_valid_i && at_last;
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/modred_decap_cu.sv
// rtl/modred_decap_cu.sv - subtract-and-compare reduction control unit; MODRED_WDOG_EN adds the subtraction watchdog
module modred_decap_cu
  import modred_pkg::*;
#(
  parameter int W       = W_COEF,
  parameter int P       = P_SNTRUP,
  parameter int MAX_SUB = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  modred_decap_cu_if.slave bus
);

  state_t       state_q, state_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] out_data_q, out_data_d;
  dp_ctrl_t     ctrl;
  logic         in_ready, out_valid;
  logic         ge;
  logic         wdog_trip;

  // q == 0 means "no reduction": the coefficient passes through untouched.
  assign ge = (bus.q != '0) && (bus.Nmod >= bus.q);

`ifdef MODRED_WDOG_EN
  localparam int SUB_W = $clog2(MAX_SUB + 2);
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             err_q, err_d;

  assign wdog_trip = ge && (sub_cnt_q == SUB_W'(MAX_SUB));

  always_comb begin
    sub_cnt_d = sub_cnt_q;
    if (state_q == ST_LOAD)     sub_cnt_d = '0;
    else if (state_q == ST_SUB) sub_cnt_d = sub_cnt_q + SUB_W'(1);
  end

  assign err_d = err_q || ((state_q == ST_CMP) && wdog_trip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign wdog_trip = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CMP;
      ST_CMP:  state_d = (ge && !wdog_trip) ? ST_SUB : ST_OUT;
      ST_SUB:  state_d = ST_CMP;
      ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl      = DP_HOLD;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_LOAD: ctrl      = DP_LOAD;
      ST_SUB:  ctrl      = DP_SUB;
      ST_OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // out_data only changes on the CMP->OUT transition, so it is stable under backpressure.
  always_comb begin
    n_d        = n_q;
    out_data_d = out_data_q;
    if ((state_q == ST_IDLE) && bus.in_valid) n_d = bus.in_data;
    if ((state_q == ST_CMP) && (state_d == ST_OUT)) out_data_d = bus.Nmod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      out_data_q <= '0;
    end else begin
      n_q        <= n_d;
      out_data_q <= out_data_d;
    end
  end

  modred_coef_cnt #(.P(P)) u_coef_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_valid_i (out_valid),
    .beat_ready_i (bus.out_ready),
    .out_last_o   (bus.out_last),
    .frame_done_o (bus.frame_done)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.N         = n_q;
  assign bus.R2        = ctrl.r2;
  assign bus.R3        = ctrl.r3;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_modred_decap_cu.sv
// tb/tb_modred_decap_cu.sv - directed self-checking bench for modred_decap_cu with a behavioural datapath
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s.%s: observed %0d, expected %0d", cur, tag, (obs), (exp)); end end

module tb_modred_decap_cu;

  localparam int W = 13;
  localparam int P = 761;
  localparam int Q = 4591;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modred_decap_cu_if #(.W(W)) bus ();

  modred_decap_cu #(.W(W), .P(P), .MAX_SUB(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (!bus.R2)      bus.Nmod <= bus.N;
    else if (!bus.R3) bus.Nmod <= bus.Nmod - bus.q;
  end

  int     tests = 0;
  int     fails = 0;
  int     beats = 0;
  string  cur   = "init";
  int     cyc, fd_cnt, idx;
  logic   fd_exp;
  logic [W-1:0] d;
  logic [W-1:0] expq[$];

  task automatic chk_rst(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s.reset_%s: observed %0d, expected %0d", cur, tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk_rst("in_ready",   W'(bus.in_ready),   W'(1))
;
    chk_rst("R2",         W'(bus.R2),         W'(1));
    chk_rst("R3",         W'(bus.R3),         W'(1));
    chk_rst("out_valid",  W'(bus.out_valid),  W'(0));
    chk_rst("out_last",   W'(bus.out_last),   W'(0));
    chk_rst("frame_done", W'(bus.frame_done), W'(0));
    chk_rst("busy",       W'(bus.busy),       W'(0));
    chk_rst("err",        W'(bus.err),        W'(0));
    chk_rst("out_data",   bus.out_data,       13'd0);
    chk_rst("N",          bus.N,              13'd0);
  endtask

  task automatic issue(input logic [W-1:0] din, input logic [W-1:0] exp_d, input int exp_lat);
    int n = 0;
    int r2lo = 0;
    `CHK("in_ready", bus.in_ready, 1'b1)
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      bus.in_valid = 1'b0;
      if (bus.R2 === 1'b0) r2lo++;
    end while (bus.out_valid !== 1'b1 && n < 200);
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $error("FAIL %s.timeout: out_valid not seen within %0d cycles", cur, n);
    end
    `CHK("latency",  n,             exp_lat)
    `CHK("out_data", bus.out_data,  exp_d)
    `CHK("r2_low",   r2lo,          1)
    `CHK("out_last", bus.out_last,  (beats % P) == (P - 1))
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    beats++;
    `CHK("idle_valid", bus.out_valid, 1'b0)
    `CHK("idle_ready", bus.in_ready,  1'b1)
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.q         = 13'(Q);

    cur = "reset";
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    cur = "r5000";  issue(13'd5000, 13'd409, 5);  accept();
    cur = "r100";   issue(13'd100,  13'd100, 3);  accept();
    cur = "r4591";  issue(13'd4591, 13'd0,   5);  accept();
    cur = "r4590";  issue(13'd4590, 13'd4590, 3); accept();

    cur = "stall";
    issue(13'd5000, 13'd409, 5);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 13'd7;
      @(posedge clk); #1;
      `CHK("hold_valid", bus.out_valid, 1'b1)
      `CHK("hold_data",  bus.out_data,  13'd409)
      `CHK("hold_ready", bus.in_ready,  1'b0)
      `CHK("hold_N",     bus.N,         13'd5000)
    end
    bus.in_valid = 1'b0;
    accept();
    `CHK("busy_after", bus.busy, 1'b0)

    cur = "q0";
    bus.q = 13'd0;
    issue(13'd8191, 13'd8191, 3);
    accept();

    cur = "wdog";
    bus.q = 13'd1;
`ifdef MODRED_WDOG_EN
    issue(13'd8191, 13'd8183, 19);
    `CHK("err", bus.err, 1'b1)
    accept();
    `CHK("err_sticky", bus.err, 1'b1)
`else
    issue(13'd20, 13'd0, 43);
    `CHK("err", bus.err, 1'b0)
    accept();
`endif

    cur = "rst_sub";
    bus.q = 13'(Q);
    bus.in_data  = 13'd8000;
    bus.in_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      bus.in_valid = 1'b0;
    end while (bus.R3 !== 1'b0 && cyc < 20);
    `CHK("reached_sub", bus.R3, 1'b0)
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats = 0;
    issue(13'd5000, 13'd409, 5);
    accept();

    cur = "frame";
    bus.out_ready = 1'b1;
    fd_exp = 1'b0;
    fd_cnt = 0;
    cyc    = 0;
    idx    = 0;
    d = 13'((idx * 613 + 5) % 8192);
    expq.push_back((d >= 13'(Q)) ? d - 13'(Q) : d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (beats < 2 * P && cyc < 12000) begin
      @(posedge clk); #1;
      cyc++;
      `CHK("frame_done", bus.frame_done, fd_exp)
      if (bus.frame_done === 1'b1) fd_cnt++;
      fd_exp = 1'b0;
      if (bus.out_valid === 1'b1) begin
        `CHK("data", bus.out_data, expq.pop_front())
        `CHK("last", bus.out_last, (beats % P) == (P - 1))
        fd_exp = ((beats % P) == (P - 1));
        beats++;
      end
      if (bus.in_ready === 1'b1 && beats < 2 * P) begin
        idx++;
        d = 13'((idx * 613 + 5) % 8192);
        expq.push_back((d >= 13'(Q)) ? d - 13'(Q) : d);
        bus.in_data = d;
      end
    end
    bus.in_valid = 1'b0;
    tests++;
    if (beats < 2 * P) begin
      fails++;
      $error("FAIL %s.timeout: only %0d beats after %0d cycles", cur, beats, cyc);
    end
    `CHK("beats", beats, 2 * P)
    @(posedge clk); #1;
    `CHK("final_done", bus.frame_done, fd_exp)
    if (bus.frame_done === 1'b1) fd_cnt++;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    `CHK("done_pulse", bus.frame_done, 1'b0)
    `CHK("done_count", fd_cnt, 2)
    `CHK("idle", bus.busy, 1'b0)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
